// File: rtl/ra_2r1w_32x32_bist.sv
// March-test initiator for the 2R1W 32x32 array wrapper.
// Issues one op per cycle and checks read data after the wrapper's read latency.
module ra_2r1w_32x32_bist #(
  parameter int unsigned LATCHRD = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [0:31] i_pattern,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [0:4]  o_fail_adr,
  output logic [0:2]  o_fail_elem,
  output logic [0:1]  o_fail_port,
  output logic [0:7]  o_fail_cnt,
  output logic        o_rd_enb_0,
  output logic        o_rd_enb_1,
  output logic [0:4]  o_rd_adr_0,
  output logic [0:4]  o_rd_adr_1,
  input  logic [0:31] i_rd_dat_0,
  input  logic [0:31] i_rd_dat_1,
  output logic        o_wr_enb_0,
  output logic [0:4]  o_wr_adr_0,
  output logic [0:31] o_wr_dat_0
);

  localparam int unsigned RD_LAT = 1 + LATCHRD;
  localparam int unsigned LAST   = RD_LAT - 1;
  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned EW     = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [EW-1:0]   r_elem, w_elem_nxt;
  logic [0:AW-1]   r_adr, w_adr_nxt;
  logic            r_ph, w_ph_nxt;
  logic            r_end, w_end_nxt;
  logic [1:0]      r_drain, w_drain_nxt;
  logic [0:DW-1]   r_pat, w_pat;
  logic            w_accept, w_issue;
  logic            w_iss_rd, w_iss_wr;
  logic [0:AW-1]   w_iss_adr;
  logic [0:DW-1]   w_iss_dat, w_iss_exp;
  logic [0:DW-1]   r_iss_exp;
  logic [EW-1:0]   r_iss_elem;

  logic            r_pv    [RD_LAT];
  logic [0:AW-1]   r_padr  [RD_LAT];
  logic [EW-1:0]   r_pelem [RD_LAT];
  logic [0:DW-1]   r_pexp  [RD_LAT];
  logic            w_mis0, w_mis1;

  // State and march cursor; the cursor points at the op issued on the next edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_elem  <= '0;
      r_adr   <= '0;
      r_ph    <= 1'b0;
      r_end   <= 1'b0;
      r_drain <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_adr   <= w_adr_nxt;
      r_ph    <= w_ph_nxt;
      r_end   <= w_end_nxt;
      r_drain <= w_drain_nxt;
      r_pat   <= w_pat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_elem_nxt  = r_elem;
    w_adr_nxt   = r_adr;
    w_ph_nxt    = r_ph;
    w_end_nxt   = r_end;
    w_iss_rd    = 1'b0;
    w_iss_wr    = 1'b0;
    w_iss_adr   = r_adr;
    w_iss_dat   = '0;
    w_iss_exp   = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_end) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == 2'(LAST)) w_state_nxt = S_DONE;
        else                     w_drain_nxt = r_drain + 2'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_pat = w_accept ? i_pattern : r_pat;

    // Odd elements read P and write ~P; even elements the reverse.
    if (w_issue) begin
      case (r_elem)
        3'd0: begin
          w_iss_wr  = 1'b1;
          w_iss_dat = w_pat;
          if (r_adr == 5'd31) begin
            w_elem_nxt = 3'd1;
            w_adr_nxt  = '0;
          end else begin
            w_adr_nxt = r_adr + 5'd1;
          end
        end
        3'd5: begin
          w_iss_rd  = 1'b1;
          w_iss_exp = w_pat;
          if (r_adr == 5'd0) w_end_nxt = 1'b1;
          else               w_adr_nxt = r_adr - 5'd1;
        end
        default: begin
          if (!r_ph) begin
            w_iss_rd  = 1'b1;
            w_iss_exp = r_elem[0] ? w_pat : ~w_pat;
            w_ph_nxt  = 1'b1;
          end else begin
            w_iss_wr  = 1'b1;
            w_iss_dat = r_elem[0] ? ~w_pat : w_pat;
            w_ph_nxt  = 1'b0;
            if (r_elem <= 3'd2) begin
              if (r_adr == 5'd31) begin
                w_elem_nxt = r_elem + 3'd1;
                w_adr_nxt  = (r_elem == 3'd1) ? 5'd0 : 5'd31;
              end else begin
                w_adr_nxt = r_adr + 5'd1;
              end
            end else begin
              if (r_adr == 5'd0) begin
                w_elem_nxt = r_elem + 3'd1;
                w_adr_nxt  = 5'd31;
              end else begin
                w_adr_nxt = r_adr - 5'd1;
              end
            end
          end
        end
      endcase
    end

    if (w_state_nxt != S_RUN) begin
      w_elem_nxt = '0;
      w_adr_nxt  = '0;
      w_ph_nxt   = 1'b0;
      w_end_nxt  = 1'b0;
    end
  end

  // Compare pipeline aligned to the wrapper read latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pv[i]    <= 1'b0;
        r_padr[i]  <= '0;
        r_pelem[i] <= '0;
        r_pexp[i]  <= '0;
      end
    end else begin
      r_pv[0]    <= o_rd_enb_0;
      r_padr[0]  <= o_rd_adr_0;
      r_pelem[0] <= r_iss_elem;
      r_pexp[0]  <= r_iss_exp;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_padr[i]  <= r_padr[i-1];
        r_pelem[i] <= r_pelem[i-1];
        r_pexp[i]  <= r_pexp[i-1];
      end
    end
  end

  assign w_mis0 = r_pv[LAST] && (i_rd_dat_0 != r_pexp[LAST]);
  assign w_mis1 = r_pv[LAST] && (i_rd_dat_1 != r_pexp[LAST]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fail      <= 1'b0;
      o_fail_adr  <= '0;
      o_fail_elem <= '0;
      o_fail_port <= '0;
      o_fail_cnt  <= '0;
      o_rd_enb_0  <= 1'b0;
      o_rd_enb_1  <= 1'b0;
      o_rd_adr_0  <= '0;
      o_rd_adr_1  <= '0;
      o_wr_enb_0  <= 1'b0;
      o_wr_adr_0  <= '0;
      o_wr_dat_0  <= '0;
      r_iss_exp   <= '0;
      r_iss_elem  <= '0;
    end else begin
      o_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      o_done     <= (w_state_nxt == S_DONE);
      o_rd_enb_0 <= w_iss_rd;
      o_rd_enb_1 <= w_iss_rd;
      o_rd_adr_0 <= w_iss_rd ? w_iss_adr : '0;
      o_rd_adr_1 <= w_iss_rd ? w_iss_adr : '0;
      o_wr_enb_0 <= w_iss_wr;
      o_wr_adr_0 <= w_iss_wr ? w_iss_adr : '0;
      o_wr_dat_0 <= w_iss_dat;
      r_iss_exp  <= w_iss_exp;
      r_iss_elem <= r_elem;
      if (w_accept) begin
        o_fail      <= 1'b0;
        o_fail_adr  <= '0;
        o_fail_elem <= '0;
        o_fail_port <= '0;
        o_fail_cnt  <= '0;
      end else if (w_mis0 || w_mis1) begin
        o_fail <= 1'b1;
        if (o_fail_cnt != 8'hFF) o_fail_cnt <= o_fail_cnt + 8'd1;
        if (!o_fail) begin
          o_fail_adr  <= r_padr[LAST];
          o_fail_elem <= r_pelem[LAST];
          o_fail_port <= {w_mis1, w_mis0};
        end
      end
    end
  end

endmodule

// File: tb/tb_ra_2r1w_32x32_bist.sv
// Directed bench: two BIST instances (LATCHRD=1 and 0), each driving a behavioural array model.
module tb_ra_2r1w_32x32_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [0:31] pat;
  logic        stuck, p1flt;

  logic        a_busy, a_done, a_fail, a_rd_enb0, a_rd_enb1, a_wr_enb;
  logic [0:4]  a_fail_adr, a_rd_adr0, a_rd_adr1, a_wr_adr;
  logic [0:2]  a_fail_elem;
  logic [0:1]  a_fail_port;
  logic [0:7]  a_fail_cnt;
  logic [0:31] a_rd_dat0, a_rd_dat1, a_wr_dat;

  logic        b_busy, b_done, b_fail, b_rd_enb0, b_rd_enb1, b_wr_enb;
  logic [0:4]  b_fail_adr, b_rd_adr0, b_rd_adr1, b_wr_adr;
  logic [0:2]  b_fail_elem;
  logic [0:1]  b_fail_port;
  logic [0:7]  b_fail_cnt;
  logic [0:31] b_rd_dat0, b_rd_dat1, b_wr_dat;

  ra_2r1w_32x32_bist #(.LATCHRD(1)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_pattern(pat),
    .o_busy(a_busy), .o_done(a_done), .o_fail(a_fail),
    .o_fail_adr(a_fail_adr), .o_fail_elem(a_fail_elem),
    .o_fail_port(a_fail_port), .o_fail_cnt(a_fail_cnt),
    .o_rd_enb_0(a_rd_enb0), .o_rd_enb_1(a_rd_enb1),
    .o_rd_adr_0(a_rd_adr0), .o_rd_adr_1(a_rd_adr1),
    .i_rd_dat_0(a_rd_dat0), .i_rd_dat_1(a_rd_dat1),
    .o_wr_enb_0(a_wr_enb), .o_wr_adr_0(a_wr_adr), .o_wr_dat_0(a_wr_dat)
  );

  ra_2r1w_32x32_bist #(.LATCHRD(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_pattern(pat),
    .o_busy(b_busy), .o_done(b_done), .o_fail(b_fail),
    .o_fail_adr(b_fail_adr), .o_fail_elem(b_fail_elem),
    .o_fail_port(b_fail_port), .o_fail_cnt(b_fail_cnt),
    .o_rd_enb_0(b_rd_enb0), .o_rd_enb_1(b_rd_enb1),
    .o_rd_adr_0(b_rd_adr0), .o_rd_adr_1(b_rd_adr1),
    .i_rd_dat_0(b_rd_dat0), .i_rd_dat_1(b_rd_dat1),
    .o_wr_enb_0(b_wr_enb), .o_wr_adr_0(b_wr_adr), .o_wr_dat_0(b_wr_dat)
  );

  // Array models: stuck-at-1 at cell 7 bit 31, optional port-1 bit 0 stuck-at-0.
  logic [0:31] a_mem [32];
  logic [0:31] b_mem [32];
  logic [0:31] a_q1, a_q2, b_q1;

  function automatic logic [0:31] rdval(input logic [0:31] v, input logic [0:4] adr);
    logic [0:31] r;
    r = v;
    if (stuck && adr == 5'd7) r[31] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_wr_enb)  a_mem[a_wr_adr] <= a_wr_dat;
    if (a_rd_enb0) a_q1 <= rdval(a_mem[a_rd_adr0], a_rd_adr0);
    a_q2 <= a_q1;
    if (b_wr_enb)  b_mem[b_wr_adr] <= b_wr_dat;
    if (b_rd_enb0) b_q1 <= rdval(b_mem[b_rd_adr0], b_rd_adr0);
  end

  assign a_rd_dat0 = a_q2;
  assign a_rd_dat1 = p1flt ? {1'b0, a_q2[1:31]} : a_q2;
  assign b_rd_dat0 = b_q1;
  assign b_rd_dat1 = p1flt ? {1'b0, b_q1[1:31]} : b_q1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected op in cycle c (1 = first cycle after the start edge).
  function automatic void exp_op(input int c, input logic [0:31] p, output logic rd,
                                 output logic wr, output logic [0:4] adr, output logic [0:31] dat);
    int k, j, e, i;
    rd = 1'b0; wr = 1'b0; adr = '0; dat = '0;
    k = c - 1;
    if (c >= 1 && c <= 320) begin
      if (k < 32) begin
        wr = 1'b1; adr = 5'(k); dat = p;
      end else if (k < 288) begin
        j = k - 32;
        e = j / 64 + 1;
        i = (j % 64) / 2;
        adr = (e <= 2) ? 5'(i) : 5'(31 - i);
        if (j % 2 == 0) rd = 1'b1;
        else begin
          wr  = 1'b1;
          dat = (e % 2 == 1) ? ~p : p;
        end
      end else begin
        rd = 1'b1; adr = 5'(31 - (k - 288));
      end
    end
  endfunction

  int          a_done_c, b_done_c, n_op, n_wr, n_rd, n_bad;
  logic        c1_fail, c1_done;
  logic [0:7]  c1_cnt;

  task automatic run_test(input logic [0:31] p, input int start_at, input int reset_at);
    logic        erd, ewr;
    logic [0:4]  eadr;
    logic [0:31] edat;
    a_done_c = 0; b_done_c = 0; n_op = 0; n_wr = 0; n_rd = 0; n_bad = 0;
    pat = p;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == start_at);
      if (c == reset_at) begin
        rst = 1'b1;
        break;
      end
      exp_op(c, p, erd, ewr, eadr, edat);
      if (a_rd_enb0 || a_wr_enb) n_op++;
      if (a_wr_enb)  n_wr++;
      if (a_rd_enb0) n_rd++;
      if (a_rd_enb0 !== erd || a_rd_enb1 !== erd || a_wr_enb !== ewr ||
          (erd && (a_rd_adr0 !== eadr || a_rd_adr1 !== eadr)) ||
          (ewr && (a_wr_adr !== eadr || a_wr_dat !== edat)))
        n_bad++;
      if (c == 1) begin
        c1_fail = a_fail; c1_cnt = a_fail_cnt; c1_done = a_done;
      end
      if (a_done && a_done_c == 0) a_done_c = c;
      if (b_done && b_done_c == 0) b_done_c = c;
      if (a_done_c != 0 && b_done_c != 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pat = '0; stuck = 1'b0; p1flt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_fail", 32'(a_fail), 0);
    chk("rst_cnt",  32'(a_fail_cnt), 0);
    chk("rst_rden", 32'(a_rd_enb0), 0);
    chk("rst_wren", 32'(a_wr_enb), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free, both latencies
    run_test(32'hA5A55A5A, 0, 0);
    chk("clean_done_lat2", 32'(a_done_c), 323);
    chk("clean_done_lat1", 32'(b_done_c), 322);
    chk("clean_ops",   32'(n_op), 320);
    chk("clean_wr",    32'(n_wr), 160);
    chk("clean_rd",    32'(n_rd), 160);
    chk("clean_opseq", 32'(n_bad), 0);
    chk("clean_busy",  32'(a_busy), 0);
    chk("clean_fail",  32'(a_fail), 0);
    chk("clean_cnt",   32'(a_fail_cnt), 0);
    chk("clean_fail_b", 32'(b_fail), 0);

    // Cell 7 bit 31 stuck-at-1, P = 0
    stuck = 1'b1;
    run_test(32'h0, 0, 0);
    stuck = 1'b0;
    chk("sa1_fail", 32'(a_fail), 1);
    chk("sa1_adr",  32'(a_fail_adr), 7);
    chk("sa1_elem", 32'(a_fail_elem), 1);
    chk("sa1_port", 32'(a_fail_port), 3);
    chk("sa1_cnt",  32'(a_fail_cnt), 3);
    chk("sa1_cnt_b", 32'(b_fail_cnt), 3);

    // Port 1 bit 0 stuck-at-0, P = 0
    p1flt = 1'b1;
    run_test(32'h0, 0, 0);
    p1flt = 1'b0;
    chk("p1_fail", 32'(a_fail), 1);
    chk("p1_adr",  32'(a_fail_adr), 0);
    chk("p1_elem", 32'(a_fail_elem), 2);
    chk("p1_port", 32'(a_fail_port), 2);
    chk("p1_cnt",  32'(a_fail_cnt), 64);
    chk("p1_port_b", 32'(b_fail_port), 2);

    // Clean rerun after failure, with a stray start during M2
    run_test(32'h3C5A0FF1, 110, 0);
    chk("rerun_c1_fail", 32'(c1_fail), 0);
    chk("rerun_c1_cnt",  32'(c1_cnt), 0);
    chk("rerun_c1_done", 32'(c1_done), 0);
    chk("rerun_done",  32'(a_done_c), 323);
    chk("rerun_opseq", 32'(n_bad), 0);
    chk("rerun_ops",   32'(n_op), 320);
    chk("rerun_fail",  32'(a_fail), 0);
    chk("rerun_cnt",   32'(a_fail_cnt), 0);

    // Reset mid-M2 of a failing run
    p1flt = 1'b1;
    run_test(32'h0, 0, 120);
    #1;
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_done", 32'(a_done), 0);
    chk("abort_fail", 32'(a_fail), 0);
    chk("abort_cnt",  32'(a_fail_cnt), 0);
    chk("abort_rden", 32'(a_rd_enb0), 0);
    chk("abort_wren", 32'(a_wr_enb), 0);
    chk("abort_busy_b", 32'(b_busy), 0);
    p1flt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_test(32'h5A5AA5A5, 0, 0);
    chk("post_done",  32'(a_done_c), 323);
    chk("post_ops",   32'(n_op), 320);
    chk("post_opseq", 32'(n_bad), 0);
    chk("post_fail",  32'(a_fail), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ra_2r1w_32x32_bist.md
Name: ra_2r1w_32x32_bist

Overview:
- March-test initiator that drives the request side of the 2R1W 32x32 SDR array wrapper: read ports 0/1 and write port 0.
- Checks returned read data against expected values and reports pass/fail plus first-failure diagnostics.
- Sits between the test/config logic and the array wrapper, muxed ahead of the functional requesters.
- Issues at most one operation per cycle, with pipelined compare matched to the wrapper's read latency.

Parameters:
- LATCHRD, 1, must match the wrapper setting; read latency RD_LAT = 1 + LATCHRD cycles from op issue to data compare.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; starts a test, honoured only when not busy
- pattern  input  [0:31]  data background P; sampled on accepted start
- busy  output  1  test in progress (RUN or DRAIN)
- done  output  1  test complete; held until next accepted start
- fail  output  1  sticky; at least one read miscompare
- fail_adr  output  [0:4]  address of first miscompare
- fail_elem  output  [0:2]  march element (1..5) of first miscompare
- fail_port  output  [0:1]  bit0 = port 0 mismatch, bit1 = port 1 mismatch, in the first failing read
- fail_cnt  output  [0:7]  failing read ops, saturates at 255
- rd_enb_0, rd_enb_1  output  1  read enables to wrapper
- rd_adr_0, rd_adr_1  output  [0:4]  read addresses; both ports carry the same address
- rd_dat_0, rd_dat_1  input  [0:31]  read data from wrapper
- wr_enb_0  output  1  write enable
- wr_adr_0  output  [0:4]  write address
- wr_dat_0  output  [0:31]  write data

Behaviour:
- All outputs registered.
- Reset, asynchronous: state IDLE; all outputs 0.
- States: IDLE -> RUN (accepted start) -> DRAIN (after last op issued, RD_LAT cycles) -> DONE -> RUN (next start).
- An accepted start clears fail, fail_adr, fail_elem, fail_port and fail_cnt, and clears done.
- start during RUN or DRAIN is ignored.
- March sequence, with ^ = address 0..31 and v = address 31..0:
  - M0: ^ w P
  - M1: ^ r P, w ~P
  - M2: ^ r ~P, w P
  - M3: v r P, w ~P
  - M4: v r ~P, w P
  - M5: v r P
- In M1..M4, each address takes 2 cycles: a read cycle (both rd_enb asserted), then a write cycle. Read and write are never issued in the same cycle.
- Op totals: 320 cycles, 160 writes, 160 reads.
- Timing: the op for cycle n is driven in cycle n; the first op appears the cycle after the start edge. All enables are 0 in cycles with no op and outside RUN.
- Compare pipeline:
  - Expected data, address, element and a valid bit are carried RD_LAT stages.
  - In the cycle where valid emerges, compare rd_dat_0 and rd_dat_1 to expected.
  - Any mismatch: set fail; fail_cnt += 1 (saturating, once per read op even if both ports mismatch).
  - First mismatch only: capture fail_adr, fail_elem and fail_port.
- DRAIN lasts exactly RD_LAT cycles, so the last compare completes before DONE.
- Result timing: done = 1 and busy = 0 first in cycle 321 + RD_LAT after the start cycle. Fail outputs are final when done rises.
- Address counter wraps in both directions without overshoot: the ^ elements end at 31, then v starts at 31.
- Reset mid-test aborts immediately. No partial results are retained; done stays 0.

Test Plan:
- Fault-free array model, P=32'hA5A55A5A, LATCHRD=1 -> 320 op cycles, 160 wr_enb pulses, 160 rd_enb_0 pulses. done rises at cycle 323 after start. fail=0, fail_cnt=0.
- Same with LATCHRD=0 -> done rises at cycle 322; fail=0.
- Array cell addr 7 bit 31 stuck-at-1, P=0 -> fail=1, fail_adr=7, fail_elem=1, fail_port=2'b11, fail_cnt=3 (fails in M1, M3, M5).
- rd_dat_1 bit 0 forced 0 on all reads, P=0 -> fail_adr=0, fail_elem=2, fail_port=2'b10, fail_cnt=64.
- start pulsed during M2 -> ignored, op sequence unchanged. reset asserted mid-M2 -> all outputs 0 immediately, busy=0, done=0. A new start then runs the full 320-op test.
- After a failing run (done=1, fail=1), start with fault removed -> fail cleared on start; final fail=0, fail_cnt=0, done re-asserts.
